muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter XLEN, default 32: operand and result width; SHALL be an even value of 8 or more.
REQ-002 Parameter TAG_W, default 5: width of the destination tag carried through with the result.
REQ-003 CLK  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 flush  input  1  synchronous abort of any operation in flight.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  unit can accept a request.
REQ-008 funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-009 data1, data2  input  XLEN  rs1 and rs2 operands.
REQ-010 in_tag  input  TAG_W  destination tag.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer takes the result.
REQ-013 result  output  XLEN  operation result.
REQ-014 out_tag  output  TAG_W  tag of the accepted request.

Function
REQ-015 States SHALL be IDLE, CALC, FIX and DONE; in_ready = (state==IDLE), and out_valid = (state==DONE).
REQ-016 Acceptance SHALL occur on a rising edge where in_valid && in_ready; funct3, data1, data2 and in_tag are latched there, so inputs may change afterwards.
REQ-017 From IDLE on acceptance, the next state SHALL be DONE for the special cases in REQ-021 and REQ-022, and CALC otherwise.
REQ-018 CALC SHALL last exactly XLEN cycles, doing one step per cycle (shift-add multiply, restoring divide on magnitudes), with a counter running XLEN-1 down to 0; then go to FIX.
REQ-019 FIX SHALL last one cycle and apply sign correction and high/low selection; then go to DONE.
REQ-020 Normal-op latency SHALL be XLEN+2 edges from acceptance to the first cycle with out_valid high (34 for XLEN=32).
REQ-021 Divide by zero SHALL give DIV and DIVU = all ones, and REM and REMU = data1, with latency 1.
REQ-022 Signed overflow (DIV or REM with data1 = most-negative and data2 = all ones) SHALL give DIV = most-negative and REM = 0, with latency 1.
REQ-023 MUL SHALL return the low XLEN bits of the 2*XLEN product.
REQ-024 MULH, MULHSU and MULHU SHALL return the high XLEN bits, treating operands as signed×signed, signed(data1)×unsigned(data2) and unsigned×unsigned respectively.
REQ-025 Quotient SHALL truncate toward zero; the remainder sign SHALL equal the dividend sign.
REQ-026 In DONE, result and out_tag SHALL hold stable until an edge with out_ready high, which moves the state to IDLE.
REQ-027 There is no accept in the same cycle as drain; the minimum issue interval SHALL be XLEN+3 cycles for normal ops and 2 cycles for special cases.
REQ-028 flush high at an edge SHALL force IDLE from any state, discard the operation, and block acceptance on that edge.
REQ-029 Precedence SHALL be RESET > flush > acceptance or drain.
REQ-030 result and out_tag SHALL be zero whenever out_valid is low.

Reset
REQ-031 RESET high at an edge SHALL set the state to IDLE, zero the counter, result, out_tag and all datapath registers, force out_valid=0, and give in_ready=1 from the next cycle.
REQ-032 RESET SHALL abort an operation mid-CALC, mid-FIX or in DONE; the result is lost and no out_valid pulse occurs.
REQ-033 Holding RESET for multiple cycles SHALL leave every output at its reset value.

Verification (XLEN=32)
REQ-034 MUL, 7 × 0xFFFFFFFD, tag 3 -> result 0xFFFFFFEB, out_tag 3, out_valid at edge +34, in_ready low in between.
REQ-035 Check the high-part ops:
- MULH 0x80000000 × 0x80000000 -> 0x40000000
- MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE
- MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF
REQ-036 Check signed divide and remainder:
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD
- REM same operands -> 0xFFFFFFFF
- DIVU 100 / 7 -> 14
- REMU 100 / 7 -> 2
REQ-037 Check the special cases, all with out_valid at edge +1:
- DIV 5 / 0 -> 0xFFFFFFFF
- REMU 5 / 0 -> 5
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000
- REM same operands -> 0
REQ-038 Backpressure: hold out_ready low 5 cycles in DONE -> result and out_tag stable, in_ready low; raise out_ready -> IDLE next edge, then accept a second request back-to-back.
REQ-039 flush at CALC cycle 10, then RESET at CALC cycle 20 of a new op -> no out_valid either time, in_ready high the cycle after, and the next op returns the correct result.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
//   One operation at a time. Multiplies use a shift-add datapath and divides a
//   restoring divider, both on operand magnitudes. Signs are re-applied in a
//   single fix-up cycle. Divide-by-zero and signed overflow bypass the datapath
//   and complete on the cycle after acceptance.
// Ports:
//   CLK, RESET        clock, synchronous active-high reset
//   flush             abort the operation in flight, blocks acceptance
//   in_valid/in_ready request handshake (funct3, data1, data2, in_tag)
//   out_valid/out_ready result handshake (result, out_tag, zero when idle)
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  data1,
    input  logic [XLEN-1:0]  data2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] out_tag
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      op_q;
    logic            neg_q;     // negate the final value in FIX
    logic [XLEN-1:0] acc_q;     // product high half / partial remainder
    logic [XLEN-1:0] lo_q;      // multiplier -> product low half / dividend -> quotient
    logic [XLEN-1:0] b_q;       // multiplicand / divisor magnitude
    logic [XLEN-1:0] result_q;
    logic [TAG_W-1:0] tag_q, out_tag_q;

    // ---- acceptance decode on the raw request ----
    logic            is_div, a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf, special;
    logic [XLEN-1:0] a_mag, b_mag, special_res;
    logic            neg_d;

    always_comb begin
        is_div   = funct3[2];
        // MUL/MULH/MULHSU treat rs1 as signed; only MUL/MULH treat rs2 as signed
        a_sgn    = is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
        b_sgn    = is_div ? ~funct3[0] : ~funct3[1];
        a_neg    = a_sgn & data1[XLEN-1];
        b_neg    = b_sgn & data2[XLEN-1];
        a_mag    = a_neg ? -data1 : data1;
        b_mag    = b_neg ? -data2 : data2;
        div_zero = is_div && (data2 == '0);
        div_ovf  = is_div && ~funct3[0] && (data1 == MIN) && (&data2);
        special  = div_zero || div_ovf;
        if (div_zero) special_res = funct3[1] ? data1 : '1;
        else          special_res = funct3[1] ? '0 : MIN;
        // remainder follows the dividend sign, everything else the product sign
        neg_d    = (is_div && funct3[1]) ? a_neg : (a_neg ^ b_neg);
    end

    // ---- one iteration step ----
    logic [XLEN:0]   mul_sum, div_rs, div_diff;
    logic [XLEN-1:0] acc_d, lo_d;

    always_comb begin
        mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        div_rs   = {acc_q, lo_q[XLEN-1]};
        div_diff = div_rs - {1'b0, b_q};
        if (!op_q[2]) begin
            acc_d = mul_sum[XLEN:1];
            lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
        end else if (!div_diff[XLEN]) begin
            acc_d = div_diff[XLEN-1:0];
            lo_d  = {lo_q[XLEN-2:0], 1'b1};
        end else begin
            acc_d = div_rs[XLEN-1:0];
            lo_d  = {lo_q[XLEN-2:0], 1'b0};
        end
    end

    // ---- sign correction and half selection ----
    logic [2*XLEN-1:0] prod_n;
    logic [XLEN-1:0]   div_v, div_n, fix_d;

    always_comb begin
        prod_n = neg_q ? -{acc_q, lo_q} : {acc_q, lo_q};
        div_v  = op_q[1] ? acc_q : lo_q;
        div_n  = neg_q ? -div_v : div_v;
        if (op_q[2])              fix_d = div_n;
        else if (op_q[1:0] == 0)  fix_d = prod_n[XLEN-1:0];
        else                      fix_d = prod_n[2*XLEN-1:XLEN];
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            acc_q     <= '0;
            lo_q      <= '0;
            b_q       <= '0;
            result_q  <= '0;
            tag_q     <= '0;
            out_tag_q <= '0;
        end else if (flush) begin
            state_q   <= IDLE;
            result_q  <= '0;
            out_tag_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    op_q  <= funct3;
                    tag_q <= in_tag;
                    neg_q <= neg_d;
                    if (special) begin
                        result_q  <= special_res;
                        out_tag_q <= in_tag;
                        state_q   <= DONE;
                    end else begin
                        acc_q   <= '0;
                        lo_q    <= a_mag;
                        b_q     <= b_mag;
                        cnt_q   <= CW'(XLEN-1);
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    lo_q  <= lo_d;
                    if (cnt_q == '0) state_q <= FIX;
                    else             cnt_q   <= cnt_q - CW'(1);
                end
                FIX: begin
                    result_q  <= fix_d;
                    out_tag_q <= tag_q;
                    state_q   <= DONE;
                end
                DONE: if (out_ready) begin
                    result_q  <= '0;
                    out_tag_q <= '0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign out_tag   = out_tag_q;
endmodule
